multicycle_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the 16-bit custom processor datapath.
//  - Fetches 16-bit instructions over a req/ack instruction-memory port and

---
 rtl/multicycle_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_seq_ctrl.sv | 564 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit datapath.
// Ports: clk, rstn (async low), start; imem req/ack/rdata + instr_addr;
//   dmem req/we/ack; alu_zero; PC_select/Jump_addr; Source2_select,
//   ALU_out_Select, Immediate_Addr, Rreg_Sig1/2, Wreg_Sig, wreg_en, OPCODE;
//   busy/halted/illegal.  Optional RETIRE_CNT_EN adds retire_cnt[15:0].
module multicycle_seq_ctrl #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [PC_W-1:0] instr_addr,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic            alu_zero,
    output logic            PC_select,
    output logic [PC_W-1:0] Jump_addr,
    output logic            Source2_select,
    output logic            ALU_out_Select,
    output logic [5:0]      Immediate_Addr,
    output logic [2:0]      Rreg_Sig1,
    output logic [2:0]      Rreg_Sig2,
    output logic [2:0]      Wreg_Sig,
    output logic            wreg_en,
    output logic [3:0]      OPCODE,
    output logic            busy,
    output logic            halted,
    output logic            illegal
`ifdef RETIRE_CNT_EN
    ,
    output logic [15:0]     retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic            r_illegal;

    logic [3:0]      w_op;
    logic            w_is_alu;
    logic            w_is_ld;
    logic            w_is_st;
    logic            w_is_jmp;
    logic            w_is_beq;
    logic            w_is_halt;
    logic            w_is_ill;
    logic            w_taken;
    logic            w_retire;
    logic            w_restart;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_imm_sx;
    logic [PC_W-1:0] w_br_tgt;
    logic [PC_W-1:0] w_jmp_tgt;

    assign w_op      = r_ir[15:12];
    assign w_is_alu  = (w_op >= 4'h1) && (w_op <= 4'h5);
    assign w_is_ld   = (w_op == 4'h6);
    assign w_is_st   = (w_op == 4'h7);
    assign w_is_jmp  = (w_op == 4'h8);
    assign w_is_beq  = (w_op == 4'h9);
    assign w_is_halt = (w_op == 4'hF);
    assign w_is_ill  = (w_op >= 4'hA) && (w_op <= 4'hE);

    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_imm_sx  = {{(PC_W-6){r_ir[5]}}, r_ir[5:0]};
    assign w_br_tgt  = w_pc_inc + w_imm_sx;
    assign w_jmp_tgt = PC_W'(r_ir[7:0]);
    assign w_taken   = w_is_jmp | (w_is_beq & alu_zero);

    // Target is only meaningful for JMP/BEQ; zero otherwise.
    assign Jump_addr = w_is_jmp ? w_jmp_tgt :
                       w_is_beq ? w_br_tgt  : '0;

    assign w_restart = start &&
                       ((r_state == S_IDLE) || (r_state == S_HALT));

    assign instr_addr     = r_pc;
    assign OPCODE         = w_op;
    assign Wreg_Sig       = r_ir[11:9];
    assign Rreg_Sig1      = r_ir[8:6];
    assign Rreg_Sig2      = r_ir[5:3];
    assign Immediate_Addr = r_ir[5:0];
    // ADDI and LD/ST address generation all take the immediate.
    assign Source2_select = (w_op == 4'h5) | w_is_ld | w_is_st;
    assign ALU_out_Select = w_is_ld;
    assign busy           = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted         = (r_state == S_HALT);
    assign illegal        = r_illegal;

    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        wreg_en   = 1'b0;
        PC_select = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                PC_select = w_taken;
                if (w_is_alu) begin
                    w_next = S_WB;
                end else if (w_is_ld || w_is_st) begin
                    w_next = S_MEM;
                end else begin
                    w_retire = 1'b1;
                    w_next   = w_is_halt ? S_HALT : S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_st;
                if (dmem_ack) begin
                    w_next   = w_is_ld ? S_WB : S_FETCH;
                    w_retire = w_is_st;
                end
            end
            S_WB: begin
                wreg_en  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                if (start) w_next = S_FETCH;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= 16'h0000;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            // PC moves only when the instruction's final state retires.
            if (w_restart)
                r_pc <= RESET_PC;
            else if (w_retire)
                r_pc <= PC_select ? Jump_addr : w_pc_inc;
            if (imem_req && imem_ack)
                r_ir <= imem_rdata;
            if (w_restart)
                r_illegal <= 1'b0;
            else if ((r_state == S_EXEC) && w_is_ill)
                r_illegal <= 1'b1;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [15:0] r_retire;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_retire <= 16'h0000;
        else if (w_restart)
            r_retire <= 16'h0000;
        else if (w_retire && (r_retire != 16'hFFFF))
            r_retire <= r_retire + 16'd1;
    end

    assign retire_cnt = r_retire;
`endif

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Scoreboard bench for multicycle_seq_ctrl: an instruction-level model
// predicts fetch order, writebacks, data accesses and latencies.
module tb_multicycle_seq_ctrl;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [7:0]  instr_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        alu_zero;
    logic        PC_select;
    logic [7:0]  Jump_addr;
    logic        Source2_select;
    logic        ALU_out_Select;
    logic [5:0]  Immediate_Addr;
    logic [2:0]  Rreg_Sig1;
    logic [2:0]  Rreg_Sig2;
    logic [2:0]  Wreg_Sig;
    logic        wreg_en;
    logic [3:0]  OPCODE;
    logic        busy;
    logic        halted;
    logic        illegal;
`ifdef RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    multicycle_seq_ctrl dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .imem_req(imem_req),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_addr(instr_addr),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_ack(dmem_ack),
        .alu_zero(alu_zero),
        .PC_select(PC_select),
        .Jump_addr(Jump_addr),
        .Source2_select(Source2_select),
        .ALU_out_Select(ALU_out_Select),
        .Immediate_Addr(Immediate_Addr),
        .Rreg_Sig1(Rreg_Sig1),
        .Rreg_Sig2(Rreg_Sig2),
        .Wreg_Sig(Wreg_Sig),
        .wreg_en(wreg_en),
        .OPCODE(OPCODE),
        .busy(busy),
        .halted(halted),
        .illegal(illegal)
`ifdef RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int idx;
        int addr;
        bit ill;
        int lat;
        bit mem;
    } fe_t;

    typedef struct {
        int idx;
        int wr;
        int rs1;
        int rs2;
        bit s2;
        bit ldsel;
        int op;
    } wb_t;

    typedef struct {
        int idx;
        bit we;
        int imm;
    } dm_t;

    fe_t fe_q[$];
    wb_t wb_q[$];
    dm_t dm_q[$];

    logic [15:0] pmem [256];
    bit          zflag [256];

    int n_tests = 0;
    int n_fail  = 0;

    int imem_fix = 0;
    int imem_max = 0;
    int dm_fix   = 0;
    int dm_max   = 0;
    bit spur     = 0;
    int icnt = 0, idly = 0;
    int dcnt = 0, ddly = 0;
    int last_dm_dly = 0;

    int cyc = 0;
    int fetch_cnt = 0;
    int cur_idx = -1;
    int last_hs_cyc = 0;
    int prev_lat = 0;
    bit prev_mem = 0;
    bit have_prev = 0;
    bit prev_req = 0;
    int last_addr = 0;

    assign alu_zero = zflag[instr_addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input int op);
        if (op >= 1 && op <= 5) return 4;
        if (op == 6) return 5;
        if (op == 7) return 4;
        return 3;
    endfunction

    // ISA-level model: walk the program from PC 0 and queue expectations.
    task automatic predict(input int n);
        int pc = 0;
        bit ill = 0;
        int op;
        int simm;
        logic [15:0] w;
        fe_t f;
        wb_t b;
        dm_t d;
        for (int k = 0; k < n; k++) begin
            w = pmem[pc];
            op = int'(w[15:12]);
            f.idx = k; f.addr = pc; f.ill = ill;
            f.lat = lat_of(op); f.mem = (op == 6 || op == 7);
            fe_q.push_back(f);
            if (op >= 1 && op <= 6) begin
                b.idx = k; b.wr = int'(w[11:9]);
                b.rs1 = int'(w[8:6]); b.rs2 = int'(w[5:3]);
                b.s2 = (op >= 5); b.ldsel = (op == 6); b.op = op;
                wb_q.push_back(b);
            end
            if (op == 6 || op == 7) begin
                d.idx = k; d.we = (op == 7); d.imm = int'(w[5:0]);
                dm_q.push_back(d);
            end
            if (op >= 10 && op <= 14) ill = 1;
            if (op == 15) break;
            if (op == 8) begin
                pc = int'(w[7:0]);
            end else if (op == 9 && zflag[pc]) begin
                simm = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
                pc = (pc + 1 + simm) & 255;
            end else begin
                pc = (pc + 1) & 255;
            end
        end
    endtask

    task automatic flush();
        fe_q.delete();
        wb_q.delete();
        dm_q.delete();
        fetch_cnt = 0;
        cur_idx = -1;
        have_prev = 0;
        prev_req = 0;
    endtask

    task automatic mon_step();
        fe_t f;
        wb_t b;
        dm_t d;
        if (imem_req && !prev_req && have_prev)
            chk("latency", cyc - last_hs_cyc,
                prev_lat + (prev_mem ? last_dm_dly : 0));
        if (wreg_en) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", wreg_en, 0);
            end else begin
                b = wb_q[0];
                chk("wb_idx", cur_idx, b.idx);
                if (b.idx == cur_idx) begin
                    void'(wb_q.pop_front());
                    chk("wb_wreg", Wreg_Sig, b.wr);
                    chk("wb_rs1", Rreg_Sig1, b.rs1);
                    chk("wb_rs2", Rreg_Sig2, b.rs2);
                    chk("wb_src2sel", Source2_select, b.s2);
                    chk("wb_aluout", ALU_out_Select, b.ldsel);
                    chk("wb_opcode", OPCODE, b.op);
                end
            end
        end
        if (dmem_req && dmem_ack) begin
            if (dm_q.size() == 0) begin
                chk("dm_unexpected", dmem_req, 0);
            end else begin
                d = dm_q[0];
                chk("dm_idx", cur_idx, d.idx);
                if (d.idx == cur_idx) begin
                    void'(dm_q.pop_front());
                    chk("dm_we", dmem_we, d.we);
                    chk("dm_imm", Immediate_Addr, d.imm);
                    chk("dm_src2sel", Source2_select, 1);
                end
            end
        end
        if (imem_req && imem_ack) begin
            cur_idx = fetch_cnt;
            if (wb_q.size() > 0 && wb_q[0].idx < cur_idx) begin
                chk("wb_missing", wb_q[0].idx, cur_idx);
                void'(wb_q.pop_front());
            end
            if (dm_q.size() > 0 && dm_q[0].idx < cur_idx) begin
                chk("dm_missing", dm_q[0].idx, cur_idx);
                void'(dm_q.pop_front());
            end
            if (fe_q.size() == 0) begin
                chk("fetch_unexpected", imem_req, 0);
            end else begin
                f = fe_q.pop_front();
                chk("fetch_addr", instr_addr, f.addr);
                chk("fetch_illegal", illegal, f.ill);
                chk("fetch_busy", busy, 1);
                last_hs_cyc = cyc;
                prev_lat = f.lat;
                prev_mem = f.mem;
                have_prev = 1;
            end
            last_addr = int'(instr_addr);
            fetch_cnt++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rstn) mon_step();
            prev_req = imem_req;
        end
    end

    initial begin
        imem_ack = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (imem_req) begin
                if (icnt == 0)
                    idly = (imem_fix >= 0) ? imem_fix
                         : int'($urandom_range(imem_max, 0));
                if (icnt == idly) begin
                    imem_ack = 1'b1;
                    imem_rdata = pmem[instr_addr];
                    icnt = 0;
                end else begin
                    icnt++;
                end
            end else begin
                icnt = 0;
                if (spur && $urandom_range(3, 0) == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = 16'($urandom);
                end
            end
        end
    end

    initial begin
        dmem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            if (dmem_req) begin
                if (dcnt == 0)
                    ddly = (dm_fix >= 0) ? dm_fix
                         : int'($urandom_range(dm_max, 0));
                if (dcnt == ddly) begin
                    dmem_ack = 1'b1;
                    last_dm_dly = ddly;
                    dcnt = 0;
                end else begin
                    dcnt++;
                end
            end else begin
                dcnt = 0;
                if (spur && $urandom_range(3, 0) == 0)
                    dmem_ack = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d fetches", fetch_cnt);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        flush();
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            pmem[i] = 16'h0000;
            zflag[i] = 1'b0;
        end
    endtask

    task automatic wait_fetches(input int n, input string nm);
        for (int i = 0; i < 3000 && fetch_cnt < n; i++) step();
        chk(nm, fetch_cnt >= n, 1);
    endtask

    task automatic wait_halt(input string nm);
        for (int i = 0; i < 500 && !halted; i++) step();
        chk(nm, halted, 1);
    endtask

    int c_dm, c_wb;
    bit we_seen, alusel;

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        clear_prog();
        step();
        step();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_wreg_en", wreg_en, 0);
        chk("rst_pc", instr_addr, 0);
        chk("rst_pcsel", PC_select, 0);
        chk("rst_jump", Jump_addr, 0);
        chk("rst_fields", {OPCODE, Wreg_Sig, Rreg_Sig1, Rreg_Sig2,
                           Immediate_Addr, Source2_select,
                           ALU_out_Select}, 0);
        chk("rst_status", {busy, halted, illegal}, 0);
        rstn = 1'b1;
        step();
        step();
        chk("idle_no_req", {imem_req, busy}, 0);

        // ADD r1,r2,r3 with immediate ack
        pmem[0] = 16'h1298;
        flush();
        predict(300);
        pulse_start();
        chk("t1_fetch", imem_req, 1);
        step();
        step();
        chk("t1_exec_no_wb", wreg_en, 0);
        step();
        chk("t1_wb_cycle4", wreg_en, 1);
        chk("t1_wreg", Wreg_Sig, 1);
        chk("t1_rs1", Rreg_Sig1, 2);
        chk("t1_rs2", Rreg_Sig2, 3);
        chk("t1_pc_before", instr_addr, 0);
        step();
        chk("t1_pc_after", instr_addr, 1);
        chk("t1_wb_single", wreg_en, 0);

        // LD with three-cycle dmem stall
        do_reset();
        clear_prog();
        pmem[0] = 16'h6845;
        dm_fix = 3;
        flush();
        predict(300);
        pulse_start();
        c_dm = 0; c_wb = 0; we_seen = 0; alusel = 0;
        for (int i = 0; i < 30 && instr_addr != 8'h01; i++) begin
            if (dmem_req) begin
                c_dm++;
                we_seen |= dmem_we;
            end
            if (wreg_en) begin
                c_wb++;
                alusel = ALU_out_Select;
            end
            step();
        end
        chk("t2_dmem_cycles", c_dm, 4);
        chk("t2_dmem_we", we_seen, 0);
        chk("t2_wreg_pulses", c_wb, 1);
        chk("t2_aluout", alusel, 1);
        chk("t2_pc", instr_addr, 1);
        dm_fix = 0;

        // JMP F0 then BEQ -1: taken loops, untaken falls through
        do_reset();
        clear_prog();
        pmem[0] = 16'h80F0;
        pmem[8'hF0] = 16'h903F;
        zflag[8'hF0] = 1'b1;
        flush();
        predict(20);
        pulse_start();
        wait_fetches(4, "t3_wait_loop");
        chk("t3_loop_addr", last_addr, 8'hF0);
        do_reset();
        zflag[8'hF0] = 1'b0;
        flush();
        predict(20);
        pulse_start();
        wait_fetches(3, "t3_wait_fall");
        chk("t3_fall_addr", last_addr, 8'hF1);

        // PC wrap at FF and sticky illegal; start while busy ignored
        do_reset();
        clear_prog();
        pmem[0] = 16'h80FF;
        pmem[8'hFF] = 16'hC000;
        flush();
        predict(20);
        pulse_start();
        wait_fetches(3, "t4_wait_wrap");
        chk("t4_wrap_addr", last_addr, 0);
        chk("t4_illegal", illegal, 1);
        pulse_start();
        wait_fetches(5, "t4_wait_more");
        chk("t4_illegal_sticky", illegal, 1);

        // HALT, start ignored mid-FETCH, start from HALT clears illegal
        do_reset();
        clear_prog();
        pmem[0] = 16'hA000;
        pmem[1] = 16'hF000;
        imem_fix = 3;
        flush();
        predict(10);
        pulse_start();
        wait_fetches(1, "t5_wait_f0");
        step();
        for (int i = 0; i < 20 && !imem_req; i++) step();
        chk("t5_in_fetch", imem_req, 1);
        pulse_start();
        wait_halt("t5_halted");
        chk("t5_busy", busy, 0);
        chk("t5_no_req", imem_req, 0);
        chk("t5_illegal_kept", illegal, 1);
        chk("t5_fetches", fetch_cnt, 2);
        flush();
        predict(10);
        pulse_start();
        chk("t5_restart_ill", illegal, 0);
        chk("t5_restart_busy", {busy, halted}, 2'b10);
        chk("t5_restart_pc", instr_addr, 0);
        wait_halt("t5_halted_again");
        imem_fix = 0;

        // Async reset during MEM drops dmem_req at once
        do_reset();
        clear_prog();
        pmem[0] = 16'h7000;
        dm_fix = 5;
        flush();
        predict(5);
        pulse_start();
        for (int i = 0; i < 20 && !dmem_req; i++) step();
        chk("t5_mem_reached", dmem_req, 1);
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_dmem_req", dmem_req, 0);
        chk("t5_rst_state", {busy, halted, imem_req}, 0);
        step();
        flush();
        rstn = 1'b1;
        step();
        step();
        chk("t5_idle_after", {busy, imem_req, dmem_req}, 0);
        dm_fix = 0;

`ifdef RETIRE_CNT_EN
        do_reset();
        clear_prog();
        pmem[0] = 16'h1298;
        pmem[1] = 16'h0000;
        pmem[2] = 16'hC000;
        pmem[3] = 16'h7000;
        pmem[4] = 16'h8005;
        pmem[5] = 16'hF000;
        flush();
        predict(10);
        pulse_start();
        wait_halt("t6_halted");
        chk("t6_retire", retire_cnt, 6);
        flush();
        predict(10);
        pulse_start();
        chk("t6_retire_clr", retire_cnt, 0);
        wait_halt("t6_halted_again");
        chk("t6_retire_again", retire_cnt, 6);
`endif

        // Randomized programs with random stalls and stray acks
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                pmem[i] = {4'($urandom_range(14, 0)), 12'($urandom)};
                zflag[i] = 1'($urandom);
            end
            imem_fix = -1;
            imem_max = 2;
            dm_fix = -1;
            dm_max = 3;
            spur = 1;
            flush();
            predict(80);
            pulse_start();
            wait_fetches(60, "rnd_wait");
        end
        spur = 0;
        imem_fix = 0;
        dm_fix = 0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
